// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame buffer: pixel word width, colour
// byte-order selectors, FSM encoding and the per-channel brightness scaler.
package ws2812_pkg;

    localparam int PIX_W  = 24;
    localparam int CHAN_W = 8;

    localparam int ORDER_RGB = 0;
    localparam int ORDER_GRB = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } fb_state_e;

    // (c * (br + 1)) >> 8 keeps 255 as identity and never exceeds 8 bits.
    function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                     input logic [CHAN_W-1:0] br);
        logic [15:0] prod;
        prod = 16'(c) * 16'({1'b0, br} + 9'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/ws2812_scale.sv
// Combinational brightness scale of the three colour channels followed by
// the byte reorder the LED string expects on the wire.
module ws2812_scale
    import ws2812_pkg::*;
#(
    parameter int GRB_ORDER = ORDER_GRB
) (
    input  logic [PIX_W-1:0]  rgb_i,
    input  logic [CHAN_W-1:0] brightness_i,
    output logic [PIX_W-1:0]  word_o
);

    logic [CHAN_W-1:0] r_s;
    logic [CHAN_W-1:0] g_s;
    logic [CHAN_W-1:0] b_s;

    assign r_s = scale_chan(rgb_i[23:16], brightness_i);
    assign g_s = scale_chan(rgb_i[15:8],  brightness_i);
    assign b_s = scale_chan(rgb_i[7:0],   brightness_i);

    assign word_o = (GRB_ORDER == ORDER_GRB) ? {g_s, r_s, b_s} : {r_s, g_s, b_s};

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Double-buffered WS2812 pixel store: pixels are scaled into a back buffer and
// published to the front buffer atomically on commit once the pipeline drains.
module ws2812_frame_buffer
    import ws2812_pkg::*;
#(
    parameter  int NUM_LEDS  = 8,
    parameter  int GRB_ORDER = 1,
    localparam int LED_BITS  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [LED_BITS-1:0]       pix_index,
    input  logic [PIX_W-1:0]          pix_rgb,
    input  logic [CHAN_W-1:0]         brightness,
    input  logic                      commit,
    output logic                      busy,
    output logic                      frame_done,
    output logic [PIX_W*NUM_LEDS-1:0] packed_rgb_data
);

    fb_state_e state_q, state_d;

    logic                 s1_vld_q,  s1_vld_d;
    logic [LED_BITS-1:0]  s1_idx_q,  s1_idx_d;
    logic [PIX_W-1:0]     s1_word_q, s1_word_d;
    logic                 s2_vld_q,  s2_vld_d;
    logic                 frame_done_q, frame_done_d;

    logic [NUM_LEDS-1:0][PIX_W-1:0] back_q,  back_d;
    logic [NUM_LEDS-1:0][PIX_W-1:0] front_q, front_d;

    logic [PIX_W-1:0] scaled_word;
    logic             accept;

    ws2812_scale #(
        .GRB_ORDER (GRB_ORDER)
    ) u_scale (
        .rgb_i        (pix_rgb),
        .brightness_i (brightness),
        .word_o       (scaled_word)
    );

    assign pix_ready       = (state_q == ST_IDLE) && !reset;
    assign accept          = pix_valid && pix_ready;
    assign busy            = (state_q != ST_IDLE) || s1_vld_q || s2_vld_q;
    assign frame_done      = frame_done_q;
    assign packed_rgb_data = front_q;

    always_comb begin
        state_d      = state_q;
        s1_vld_d     = accept;
        s1_idx_d     = accept ? pix_index   : s1_idx_q;
        s1_word_d    = accept ? scaled_word : s1_word_q;
        // Stage 2 marks the cycle the back buffer is written, so a swap never
        // races a write still landing.
        s2_vld_d     = s1_vld_q;
        back_d       = back_q;
        front_d      = front_q;
        frame_done_d = 1'b0;

        // Out-of-range indices match no entry and are dropped here.
        for (int n = 0; n < NUM_LEDS; n++) begin
            if (s1_vld_q && (s1_idx_q == LED_BITS'(n))) begin
                back_d[n] = s1_word_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (commit) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d      = ST_SWAP;
                    front_d      = back_q;
                    frame_done_d = 1'b1;
                end
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s1_vld_q     <= 1'b0;
            s1_idx_q     <= '0;
            s1_word_q    <= '0;
            s2_vld_q     <= 1'b0;
            frame_done_q <= 1'b0;
            back_q       <= '0;
            front_q      <= '0;
        end else begin
            state_q      <= state_d;
            s1_vld_q     <= s1_vld_d;
            s1_idx_q     <= s1_idx_d;
            s1_word_q    <= s1_word_d;
            s2_vld_q     <= s2_vld_d;
            frame_done_q <= frame_done_d;
            back_q       <= back_d;
            front_q      <= front_d;
        end
    end

endmodule

// File: doc/ws2812_frame_buffer.md
WS2812_FRAME_BUFFER -- requirements
Module: ws2812_frame_buffer

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LEDs held; must match the downstream serialiser.
REQ-002 Parameter GRB_ORDER, default 1: 1 = pack bytes G,R,B MSB-first per LED; 0 = R,G,B.
REQ-003 Localparam LED_BITS = $clog2(NUM_LEDS), minimum 1.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_valid  input  1  pixel write request.
REQ-007 pix_ready  output  1  pixel write can be accepted.
REQ-008 pix_index  input  LED_BITS  target LED index.
REQ-009 pix_rgb  input  24  colour as R[23:16], G[15:8], B[7:0].
REQ-010 brightness  input  8  global scale factor, sampled per pixel.
REQ-011 commit  input  1  single-cycle request to publish the back buffer.
REQ-012 busy  output  1  commit pending or pipeline non-empty.
REQ-013 frame_done  output  1  single-cycle pulse after the front buffer is updated.
REQ-014 packed_rgb_data  output  24*NUM_LEDS  front buffer; LED n occupies bits [24n+23:24n].

Function
REQ-015 A pixel SHALL be accepted on a rising edge where pix_valid && pix_ready.
REQ-016 pix_ready SHALL be combinational: 1 only in state IDLE and not in reset.
REQ-017 Each channel SHALL be scaled as (c*(brightness+1))>>8, giving 8-bit results with no overflow; brightness 255 is identity and brightness 0 yields 0.
REQ-018 Latency: a pixel accepted at edge E SHALL be registered into stage 1 at E; the scaled, reordered word SHALL be written to back[pix_index] at E+1.
REQ-019 A pixel with pix_index >= NUM_LEDS SHALL be accepted and discarded, with no buffer write.
REQ-020 Successive writes to the same index SHALL resolve last-write-wins, in order.
REQ-021 The FSM SHALL have states IDLE, DRAIN and SWAP.
REQ-022 IDLE SHALL go to DRAIN on commit; a pixel accepted in the same cycle as commit is included in the frame.
REQ-023 DRAIN SHALL go to SWAP on the first edge where both pipeline stages are empty.
REQ-024 On entry to SWAP, the state SHALL copy front <= back, assert frame_done for exactly that cycle, and return to IDLE on the next edge.
REQ-025 commit SHALL be ignored in DRAIN and SWAP, with no queuing.
REQ-026 The back buffer SHALL persist across commits and SHALL NOT be cleared.
REQ-027 packed_rgb_data SHALL change only on the swap edge, so no partial frame is ever visible.
REQ-028 busy = (state != IDLE) || either stage valid.

Reset
REQ-029 Asserting reset SHALL immediately clear, regardless of clk: state to IDLE, both pipeline valids to 0, back and front buffers to 0, packed_rgb_data to 0, frame_done to 0, busy to 0.
REQ-030 Reset asserted mid-DRAIN or mid-SWAP SHALL abort the commit; no frame_done pulse is produced.
REQ-031 pix_ready SHALL read 0 while reset is high and 1 on the first cycle after release.

Structure
REQ-032 Shared package ws2812_pkg SHALL hold the colour byte-order constants, the FSM state encoding, and the 24-bit pixel word width.
REQ-033 The per-channel scale-and-reorder datapath SHALL be sub-module ws2812_scale, instantiated once: three 8x9 multiplies and byte reorder, purely combinational, registered by the parent.

Verification
REQ-034 Reset, write idx 0 rgb 24'hFF8040 at brightness 255, then commit: frame_done pulses once, and packed_rgb_data[23:0] = 24'h80FF40 with GRB_ORDER=1.
REQ-035 Brightness 127 on rgb 24'hFF_FF_02: stored channels 8'h7F, 8'h7F, 8'h01; brightness 0 stores 24'h000000.
REQ-036 Back-to-back writes to idx 3 (AA,BB,CC) then idx 3 (11,22,33) with commit on the second accept cycle: front LED3 holds the second value, and pix_ready is low from the next cycle until after frame_done.
REQ-037 Write idx NUM_LEDS (out of range), then commit: front buffer is unchanged and frame_done still pulses.
REQ-038 Commit with an idle pipeline: DRAIN for 1 cycle, frame_done in the following cycle; a second commit during DRAIN produces no extra pulse.
REQ-039 Assert reset during DRAIN after writes: all outputs are 0, there is no frame_done, and pix_ready = 1 after release.
